// File: rtl/systolic_ctrl_if.sv
// Handshake and control bundle between the systolic array sequencer and its
// operand buffer, PE array edge and result consumer.
interface systolic_ctrl_if #(
  parameter int N  = 4,
  parameter int KW = 8
);
  localparam int CW = $clog2(N);

  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          op_rd_en;
  logic [KW-1:0] op_rd_addr;
  logic          cal_ele_cho;
  logic          mem_ele_cho;
  logic          mem_change;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_col;

  modport master (
    input  start, k_len, res_ready,
    output busy, done, op_rd_en, op_rd_addr, cal_ele_cho,
           mem_ele_cho, mem_change, res_valid, res_col
  );

  modport slave (
    output start, k_len, res_ready,
    input  busy, done, op_rd_en, op_rd_addr, cal_ele_cho,
           mem_ele_cho, mem_change, res_valid, res_col
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N systolic array: feeds K operand steps, flushes
// the skewed wavefront, captures results and shifts columns out.
module systolic_ctrl #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic            clk,
  input  logic            reset,
  systolic_ctrl_if.master bus
);
  localparam int CW = $clog2(N);
  localparam int FW = $clog2(2 * N);
  localparam logic [KW-1:0] STEP_ONE   = KW'(1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);
  localparam logic [CW-1:0] COL_LAST   = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, FEED, FLUSH, LOAD, SHIFT, DONE} state_t;

  state_t        state;
  logic [KW-1:0] k_q;
  logic [KW-1:0] step;
  logic [FW-1:0] flush_cnt;
  logic [CW-1:0] col;
  logic          busy_q;
  logic          done_q;
  logic          rd_en_q;
  logic          cal_q;
  logic          load_q;
  logic          shift_q;

  // Outputs are registered alongside the next state so they track the state
  // they belong to; only mem_change follows res_ready combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k_q       <= '0;
      step      <= '0;
      flush_cnt <= '0;
      col       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      cal_q     <= 1'b0;
      load_q    <= 1'b0;
      shift_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            k_q    <= bus.k_len;
            busy_q <= 1'b1;
            step   <= '0;
            if (bus.k_len != '0) begin
              state   <= FEED;
              rd_en_q <= 1'b1;
              cal_q   <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        FEED: begin
          cal_q <= 1'b0;
          if (step == k_q - STEP_ONE) begin
            state     <= FLUSH;
            rd_en_q   <= 1'b0;
            step      <= '0;
            flush_cnt <= '0;
          end else begin
            step <= step + STEP_ONE;
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state  <= LOAD;
            load_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        LOAD: begin
          state   <= SHIFT;
          load_q  <= 1'b0;
          shift_q <= 1'b1;
          col     <= '0;
        end
        SHIFT: begin
          // A stalled consumer simply holds everything in place.
          if (bus.res_ready) begin
            if (col == COL_LAST) begin
              state   <= DONE;
              shift_q <= 1'b0;
              done_q  <= 1'b1;
              col     <= '0;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rd_en_q <= 1'b0;
          cal_q   <= 1'b0;
          load_q  <= 1'b0;
          shift_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.op_rd_en    = rd_en_q;
  assign bus.op_rd_addr  = step;
  assign bus.cal_ele_cho = cal_q;
  assign bus.mem_ele_cho = shift_q;
  assign bus.mem_change  = load_q | (shift_q & bus.res_ready);
  assign bus.res_valid   = shift_q;
  assign bus.res_col     = col;
endmodule
